serial_alu_seq: RTL and testbench

- Bit-serial sequencer that computes a full WIDTH-bit ALU operation with a single 1-bit ALU slice.
- The operation runs LSB first, one bit per clock.
- The block owns the operand shift registers, the carry flop, the result register and the start/busy/done handshake.
- Intended as the area-minimal ALU option in the multicycle/teaching datapath, and as the controller that exercises the existing 1-bit slice.

---
 rtl/alu_ctrl_pkg.sv | 42 ++++
 rtl/serial_alu_seq_slice.sv | 32 +++
 rtl/serial_alu_seq.sv | 133 +++++++++++++
 tb/tb_serial_alu_seq.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: op codes, 1-bit slice selects and FSM states.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] SEL_AND   = 2'b00;
  localparam logic [1:0] SEL_OR    = 2'b01;
  localparam logic [1:0] SEL_ARITH = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Legal op codes are the five listed above; everything else yields zero.
  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // Slice select for an op; illegal ops fall back to AND (of zeroed operands).
  function automatic logic [1:0] op_sel(input logic [2:0] op);
    logic [1:0] sel;
    case (op)
      OP_OR:                 sel = SEL_OR;
      OP_ADD, OP_SUB, OP_SLT: sel = SEL_ARITH;
      default:               sel = SEL_AND;
    endcase
    return sel;
  endfunction

  // B is inverted (and carry seeded to 1) for subtract-style ops.
  function automatic logic op_invert(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/serial_alu_seq_slice.sv
// One-bit ALU slice: AND / OR / full-adder sum with optional B inversion.
module ALU_1bit
  import alu_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       invert_b,
  input  logic       cin,
  input  logic [1:0] sel,
  output logic       data_out,
  output logic       cout
);

  logic b_eff;
  logic sum;

  assign b_eff = b ^ invert_b;
  assign sum   = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

  // Output mux selected by the decoded op.
  always_comb begin
    data_out = 1'b0;
    case (sel)
      SEL_AND:   data_out = a & b_eff;
      SEL_OR:    data_out = a | b_eff;
      SEL_ARITH: data_out = sum;
      default:   data_out = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: one bit per clock, LSB first, through a single
// 1-bit slice. Handshake: a request is taken when start=1 while the block is
// ready (IDLE or DONE); busy is high while bits are processed; done is a
// one-cycle pulse in which result/zero/overflow first show the new values.
module serial_alu_seq
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] acc;
  logic             carry;
  logic             invert;
  logic [2:0]       op_q;

  logic             ready;
  logic             accept;
  logic             last_bit;
  logic [1:0]       sel;
  logic             slice_out;
  logic             slice_cout;
  logic [WIDTH-1:0] shifted;
  logic             arith_ov;
  logic             less;
  logic [WIDTH-1:0] final_res;
  logic             final_ov;

  assign ready    = (state == ST_IDLE) || (state == ST_DONE);
  assign accept   = start && ready;
  assign last_bit = (state == ST_RUN) && (count == CNT_W'(WIDTH - 1));
  assign sel      = op_sel(op_q);

  ALU_1bit u_slice (
    .a        (a_sh[0]),
    .b        (b_sh[0]),
    .invert_b (invert),
    .cin      (carry),
    .sel      (sel),
    .data_out (slice_out),
    .cout     (slice_cout)
  );

  // The newest bit enters from the MSB side; on the last bit this is the full result.
  assign shifted = {slice_out, acc};

  // On the last bit, carry holds the MSB carry-in and slice_cout the MSB carry-out.
  assign arith_ov  = carry ^ slice_cout;
  assign less      = slice_out ^ arith_ov;
  assign final_ov  = ((op_q == OP_ADD) || (op_q == OP_SUB)) && arith_ov;
  assign final_res = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, less} : shifted;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = start ? ST_RUN : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand shifters, carry, bit counter and the held result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      invert   <= 1'b0;
      op_q     <= OP_AND;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      count  <= '0;
      a_sh   <= op_legal(op) ? data_a : '0;
      b_sh   <= op_legal(op) ? data_b : '0;
      acc    <= '0;
      carry  <= op_invert(op);
      invert <= op_invert(op);
      op_q   <= op;
    end else if (state == ST_RUN) begin
      carry <= slice_cout;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      acc   <= shifted[WIDTH-1:1];
      count <= count + CNT_W'(1);
      if (last_bit) begin
        result   <= final_res;
        zero     <= (final_res == '0);
        overflow <= final_ov;
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq with a behavioural arithmetic model.
module tb_serial_alu_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_ov_q[$];

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .data_a   (data_a),
    .data_b   (data_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: signed arithmetic in 64 bits, overflow by range check.
  function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] r,
                                    output logic v);
    longint sa;
    longint sb;
    longint s;
    sa = $signed(a);
    sb = $signed(b);
    s  = 0;
    r  = '0;
    v  = 1'b0;
    case (o)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        s = sa + sb;
        r = s[W-1:0];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b110: begin
        s = sa - sb;
        r = s[W-1:0];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
  endfunction

  // Driver: launch one op (called #1 after an edge), return in the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_n, output bit to);
    op     = o;
    data_a = a;
    data_b = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    op     = 3'($urandom);
    data_a = $urandom;
    data_b = $urandom;
    lat    = 0;
    busy_n = 0;
    to     = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) busy_n++;
      if (lat >= 200) begin
        to = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = '0; data_a = '0; data_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, zero, overflow} !== 4'b0000 || result !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b zero=%b ov=%b result=%h expected all 0",
               busy, done, zero, overflow, result);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow;
    int lat; int bn; bit to;
    run_op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, lat, bn, to);
    checks++;
    if (to || lat != W) begin
      errors++;
      $display("FAIL add_latency: got %0d edges (timeout=%0d) expected %0d", lat, to, W);
    end
    checks++;
    if (bn != W) begin
      errors++;
      $display("FAIL add_busy_cycles: got %0d expected %0d", bn, W);
    end
    checks++;
    if (result !== 32'h8000_0000 || overflow !== 1'b1 || zero !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_ovf: result=%h ov=%b zero=%b busy=%b expected 80000000 1 0 0",
               result, overflow, zero, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b expected 0 one cycle after done", done);
    end
  endtask

  task automatic test_sub_zero;
    int lat; int bn; bit to;
    run_op(3'b110, 32'h5, 32'h5, lat, bn, to);
    checks++;
    if (to || result !== '0 || zero !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL sub_zero: result=%h zero=%b ov=%b to=%0d expected 0 1 0", result, zero, overflow, to);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_slt;
    int lat; int bn; bit to;
    run_op(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, lat, bn, to);
    checks++;
    if (to || result !== 32'd1 || overflow !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL slt_neg: result=%h ov=%b zero=%b expected 1 0 0", result, overflow, zero);
    end
    @(posedge clk); #1;
    run_op(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, lat, bn, to);
    checks++;
    if (to || result !== 32'd0 || overflow !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL slt_ovf: result=%h ov=%b zero=%b expected 0 0 1", result, overflow, zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_logic;
    int lat; int bn; bit to;
    run_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, bn, to);
    checks++;
    if (to || result !== 32'hF000_F000 || zero !== 1'b0) begin
      errors++;
      $display("FAIL and: result=%h zero=%b expected f000f000 0", result, zero);
    end
    run_op(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, bn, to);
    checks++;
    if (to || result !== 32'hFFF0_FFF0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL or: result=%h ov=%b expected fff0fff0 0", result, overflow);
    end
    run_op(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, bn, to);
    checks++;
    if (to || lat != W || result !== '0 || zero !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL illegal_op: result=%h zero=%b ov=%b lat=%0d expected 0 1 0 %0d",
               result, zero, overflow, lat, W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start;
    int lat;
    op = 3'b010; data_a = 32'h1234_5678; data_b = 32'h1111_1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    op = 3'b000; data_a = 32'hFFFF_FFFF; data_b = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 6;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != W || result !== 32'h2345_6789) begin
      errors++;
      $display("FAIL ignore_start: result=%h lat=%0d expected 23456789 %0d", result, lat, W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat; int bn; bit to; int gap;
    run_op(3'b010, 32'h0000_00FF, 32'h0000_0001, lat, bn, to);
    checks++;
    if (to || result !== 32'h0000_0100) begin
      errors++;
      $display("FAIL b2b_first: result=%h expected 00000100", result);
    end
    op = 3'b110; data_a = 32'h0000_0010; data_b = 32'h0000_0020; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 32'h0000_0100) begin
      errors++;
      $display("FAIL b2b_no_gap: busy=%b done=%b result=%h expected 1 0 00000100", busy, done, result);
    end
    gap = 1;
    while (done !== 1'b1 && gap < 200) begin
      @(posedge clk); #1;
      gap++;
    end
    checks++;
    if (gap != W + 1 || result !== 32'hFFFF_FFF0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: gap=%0d result=%h ov=%b expected %0d fffffff0 0",
               gap, result, overflow, W + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    int lat; int bn; bit to; int seen;
    op = 3'b010; data_a = 32'h0F0F_0F0F; data_b = 32'h0101_0101; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h zero=%b ov=%b expected all 0",
               busy, done, result, zero, overflow);
    end
    seen = 0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_done: %0d active cycles after reset expected 0", seen);
    end
    run_op(3'b010, 32'h0F0F_0F0F, 32'h0101_0101, lat, bn, to);
    checks++;
    if (to || lat != W || result !== 32'h1010_1010) begin
      errors++;
      $display("FAIL after_reset: result=%h lat=%0d expected 10101010 %0d", result, lat, W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [2:0]   ops[8];
    logic [W-1:0] corners[6];
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         v;
    logic [W-1:0] er;
    logic         ev;
    logic [2:0]   o;
    int lat; int bn; bit to;
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
    corners = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1, 32'h8000_0001};
    for (int n = 0; n < 40; n++) begin
      o = ops[$urandom_range(0, 7)];
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
      if (n % 7 == 3) b = a;
      ref_model(o, a, b, r, v);
      exp_q.push_back(r);
      exp_ov_q.push_back(v);
      run_op(o, a, b, lat, bn, to);
      er = exp_q.pop_front();
      ev = exp_ov_q.pop_front();
      checks++;
      if (to || lat != W || result !== er || overflow !== ev || zero !== (er == '0)) begin
        errors++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: result=%h ov=%b zero=%b lat=%0d expected %h %b %b %0d",
                 n, o, a, b, result, overflow, zero, lat, er, ev, (er == '0), W);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_sub_zero;
    test_slt;
    test_logic;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
